// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: count-mode encodings reused by
// counter_prog and future counter variants.
package counter_pkg;

  localparam int CNT_MODE_W = 2;

  localparam logic [CNT_MODE_W-1:0] CNT_MODE_UP      = 2'd0;
  localparam logic [CNT_MODE_W-1:0] CNT_MODE_DOWN    = 2'd1;
  localparam logic [CNT_MODE_W-1:0] CNT_MODE_UPDOWN  = 2'd2;
  localparam logic [CNT_MODE_W-1:0] CNT_MODE_ONESHOT = 2'd3;

endpackage

// File: rtl/counter_tc_detect.sv
// Same-cycle terminal-count detection for the counter family: compares the
// current count against zero and against the programmed limit.
module counter_tc_detect #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] limit,
  output logic             at_zero,
  output logic             at_limit,
  output logic             over_limit
);

  assign at_zero    = (cnt == '0);
  assign at_limit   = (cnt == limit);
  // Only possible when limit is lowered at runtime below the live count.
  assign over_limit = (cnt > limit);

endmodule

// File: rtl/counter_prog.sv
// Programmable-modulo counter with enable, synchronous load and four count
// modes (up, down, ping-pong, one-shot); terminal count is a registered pulse.
module counter_prog
  import counter_pkg::*;
#(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      limit,
  input  logic [CNT_MODE_W-1:0] mode,
  output logic [WIDTH-1:0]      cnt_o,
  output logic                  flag,
  output logic                  dir_o,
  output logic                  done
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             flag_q, flag_d;
  logic             at_zero, at_limit, over_limit;

  counter_tc_detect #(
    .WIDTH (WIDTH)
  ) u_tc_detect (
    .cnt        (cnt_q),
    .limit      (limit),
    .at_zero    (at_zero),
    .at_limit   (at_limit),
    .over_limit (over_limit)
  );

  always_comb begin
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    done_d = done_q;
    flag_d = 1'b0;

    if (load) begin
      cnt_d  = (load_val > limit) ? limit : load_val;
      done_d = 1'b0;
      dir_d  = (mode == CNT_MODE_DOWN);
    end else if (en) begin
      if (over_limit) begin
        // Limit dropped under the count: restart cleanly, no terminal event.
        cnt_d = '0;
        dir_d = 1'b0;
      end else begin
        case (mode)
          CNT_MODE_UP: begin
            dir_d = 1'b0;
            if (at_limit) begin
              cnt_d  = '0;
              flag_d = 1'b1;
            end else begin
              cnt_d = cnt_q + ONE;
            end
          end
          CNT_MODE_DOWN: begin
            dir_d = 1'b1;
            if (at_zero) begin
              cnt_d  = limit;
              flag_d = 1'b1;
            end else begin
              cnt_d = cnt_q - ONE;
            end
          end
          CNT_MODE_UPDOWN: begin
            if (at_zero && at_limit) begin
              // Degenerate range 0..0: every enabled edge is a turnaround.
              cnt_d  = '0;
              dir_d  = 1'b0;
              flag_d = 1'b1;
            end else if (!dir_q) begin
              if (at_limit) begin
                cnt_d  = limit - ONE;
                dir_d  = 1'b1;
                flag_d = 1'b1;
              end else begin
                cnt_d = cnt_q + ONE;
              end
            end else begin
              if (at_zero) begin
                cnt_d  = ONE;
                dir_d  = 1'b0;
                flag_d = 1'b1;
              end else begin
                cnt_d = cnt_q - ONE;
              end
            end
          end
          default: begin
            // One-shot: count up once to limit, then park until load/reset.
            if (!done_q) begin
              if (at_limit) begin
                done_d = 1'b1;
                flag_d = 1'b1;
              end else begin
                cnt_d = cnt_q + ONE;
              end
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= RST_VAL;
      dir_q  <= 1'b0;
      done_q <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      done_q <= done_d;
      flag_q <= flag_d;
    end
  end

  assign cnt_o = cnt_q;
  assign flag  = flag_q;
  assign dir_o = dir_q;
  assign done  = done_q;

endmodule

// File: tb/tb_counter_prog.sv
// Self-checking bench for counter_prog (WIDTH=4, RST_VAL=0): vector table plus
// hand-written corner sequences, checked through an expected-value queue.
module tb_counter_prog;
  import counter_pkg::*;

  localparam int W     = 4;
  localparam int EXP_W = W + 3;

  localparam logic [1:0] UP = CNT_MODE_UP;
  localparam logic [1:0] DN = CNT_MODE_DOWN;
  localparam logic [1:0] UD = CNT_MODE_UPDOWN;
  localparam logic [1:0] OS = CNT_MODE_ONESHOT;

  logic         clk;
  logic         reset;
  logic         en;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] limit;
  logic [1:0]   mode;
  logic [W-1:0] cnt_o;
  logic         flag;
  logic         dir_o;
  logic         done;

  typedef struct {
    logic         rst;
    logic         en;
    logic         ld;
    logic [W-1:0] lv;
    logic [W-1:0] lim;
    logic [1:0]   md;
    logic [W-1:0] c;
    logic         f;
    logic         d;
    logic         dn;
  } vec_t;

  vec_t vecs[$];
  logic [EXP_W-1:0] exp_q[$];
  int n_checks;
  int n_fail;

  counter_prog #(
    .WIDTH   (W),
    .RST_VAL (4'd0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .mode     (mode),
    .cnt_o    (cnt_o),
    .flag     (flag),
    .dir_o    (dir_o),
    .done     (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic void add(input logic rst, input logic e, input logic ld,
                              input logic [W-1:0] lv, input logic [W-1:0] lim,
                              input logic [1:0] md, input logic [W-1:0] c,
                              input logic f, input logic d, input logic dn);
    vec_t v;
    v.rst = rst; v.en = e; v.ld = ld; v.lv = lv; v.lim = lim; v.md = md;
    v.c = c; v.f = f; v.d = d; v.dn = dn;
    vecs.push_back(v);
  endfunction

  // scoreboard compare: one expected entry per clock edge
  task automatic check(input int id);
    logic [EXP_W-1:0] got;
    logic [EXP_W-1:0] exp;
    got = {cnt_o, flag, dir_o, done};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL vec%0d: no expected entry queued, got cnt/flag/dir/done %0d/%0b/%0b/%0b",
               id, cnt_o, flag, dir_o, done);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        n_fail++;
        $display("FAIL vec%0d: cnt/flag/dir/done got %0d/%0b/%0b/%0b expected %0d/%0b/%0b/%0b",
                 id, cnt_o, flag, dir_o, done,
                 exp[EXP_W-1:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  // driver: apply inputs away from the edge, queue the expectation, sample after it
  task automatic drive(input vec_t v, input int id);
    @(negedge clk);
    reset    = v.rst;
    en       = v.en;
    load     = v.ld;
    load_val = v.lv;
    limit    = v.lim;
    mode     = v.md;
    exp_q.push_back({v.c, v.f, v.d, v.dn});
    @(posedge clk);
    #1;
    check(id);
  endtask

  initial begin
    int id;
    logic [W-1:0] rv;
    vec_t v;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; en = 1'b0; load = 1'b0; load_val = '0; limit = '0; mode = UP;

    // reset with load and en asserted still wins
    add(1, 1, 1, 5, 5, UP, 0, 0, 0, 0);
    // UP, limit 5: 1..5,0,1..5,0,1 with flag on each wrap
    for (int i = 0; i < 13; i++) begin
      logic [W-1:0] c;
      c = W'((i + 1) % 6);
      add(0, 1, 0, 0, 5, UP, c, (c == 0), 0, 0);
    end
    // DOWN: load 3, limit 9 -> 3,2,1,0,9(flag),8
    add(0, 0, 1, 3, 9, DN, 3, 0, 1, 0);
    add(0, 1, 0, 0, 9, DN, 2, 0, 1, 0);
    add(0, 1, 0, 0, 9, DN, 1, 0, 1, 0);
    add(0, 1, 0, 0, 9, DN, 0, 0, 1, 0);
    add(0, 1, 0, 0, 9, DN, 9, 1, 1, 0);
    add(0, 1, 0, 0, 9, DN, 8, 0, 1, 0);
    // UPDOWN, limit 3 -> 0,1,2,3,2(flag),1,0,1(flag)
    add(0, 0, 1, 0, 3, UD, 0, 0, 0, 0);
    add(0, 1, 0, 0, 3, UD, 1, 0, 0, 0);
    add(0, 1, 0, 0, 3, UD, 2, 0, 0, 0);
    add(0, 1, 0, 0, 3, UD, 3, 0, 0, 0);
    add(0, 1, 0, 0, 3, UD, 2, 1, 1, 0);
    add(0, 1, 0, 0, 3, UD, 1, 0, 1, 0);
    add(0, 1, 0, 0, 3, UD, 0, 0, 1, 0);
    add(0, 1, 0, 0, 3, UD, 1, 1, 0, 0);
    // mode changes without load
    add(0, 1, 0, 0, 3, UD, 2, 0, 0, 0);
    add(0, 1, 0, 0, 3, UD, 3, 0, 0, 0);
    add(0, 1, 0, 0, 3, UD, 2, 1, 1, 0);
    add(0, 1, 0, 0, 3, UP, 3, 0, 0, 0);
    add(0, 1, 0, 0, 3, DN, 2, 0, 1, 0);
    add(0, 1, 0, 0, 3, UP, 3, 0, 0, 0);
    add(0, 1, 0, 0, 3, UP, 0, 1, 0, 0);
    // UPDOWN with limit 0: flag every enabled edge
    add(0, 0, 1, 0, 0, UD, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, UD, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, UD, 0, 1, 0, 0);
    // ONESHOT, limit 4
    add(0, 0, 1, 0, 4, OS, 0, 0, 0, 0);
    add(0, 1, 0, 0, 4, OS, 1, 0, 0, 0);
    add(0, 1, 0, 0, 4, OS, 2, 0, 0, 0);
    add(0, 1, 0, 0, 4, OS, 3, 0, 0, 0);
    add(0, 1, 0, 0, 4, OS, 4, 0, 0, 0);
    add(0, 1, 0, 0, 4, OS, 4, 1, 0, 1);
    add(0, 1, 0, 0, 4, OS, 4, 0, 0, 1);
    add(0, 1, 0, 0, 4, OS, 4, 0, 0, 1);
    add(0, 0, 1, 1, 4, OS, 1, 0, 0, 0);
    add(0, 1, 0, 0, 4, OS, 2, 0, 0, 0);
    add(0, 1, 0, 0, 4, OS, 3, 0, 0, 0);
    add(0, 1, 0, 0, 4, OS, 4, 0, 0, 0);
    add(0, 1, 0, 0, 4, OS, 4, 1, 0, 1);
    // en low: everything holds for 5 cycles, flag drops
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 4, OS, 4, 0, 0, 1);
    // limit lowered under the count: next enabled edge -> 0, no flag
    add(0, 0, 1, 10, 15, UP, 10, 0, 0, 0);
    add(0, 1, 0, 0, 6, UP, 0, 0, 0, 0);
    add(0, 1, 0, 0, 6, UP, 1, 0, 0, 0);
    // load clamp: 12 with limit 7 -> 7, then wrap
    add(0, 0, 1, 12, 7, UP, 7, 0, 0, 0);
    add(0, 1, 0, 0, 7, UP, 0, 1, 0, 0);
    add(0, 1, 0, 0, 7, UP, 1, 0, 0, 0);
    add(0, 1, 0, 0, 7, UP, 2, 0, 0, 0);
    // reset mid-count with load and en high
    add(1, 1, 1, 9, 7, UP, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) drive(vecs[i], i);
    id = vecs.size();

    // hand sequence: random over-limit load in DOWN clamps and sets dir
    for (int k = 0; k < 4; k++) begin
      rv = W'($urandom_range(8, 15));
      v = '{rst: 0, en: 0, ld: 1, lv: rv, lim: 7, md: DN, c: 7, f: 0, d: 1, dn: 0};
      drive(v, id++);
      v = '{rst: 0, en: 1, ld: 0, lv: 0, lim: 7, md: DN, c: 6, f: 0, d: 1, dn: 0};
      drive(v, id++);
    end

    // hand sequence: random in-range loads in UP take effect unmodified
    for (int k = 0; k < 4; k++) begin
      rv = W'($urandom_range(0, 6));
      v = '{rst: 0, en: 1, ld: 1, lv: rv, lim: 7, md: UP, c: rv, f: 0, d: 0, dn: 0};
      drive(v, id++);
      v = '{rst: 0, en: 1, ld: 0, lv: 0, lim: 7, md: UP, c: rv + 4'd1, f: 0, d: 0, dn: 0};
      drive(v, id++);
    end

    // hand sequence: reset on the edge that would have flagged aborts the pulse
    v = '{rst: 0, en: 0, ld: 1, lv: 0, lim: 7, md: DN, c: 0, f: 0, d: 1, dn: 0};
    drive(v, id++);
    v = '{rst: 1, en: 1, ld: 0, lv: 0, lim: 7, md: DN, c: 0, f: 0, d: 0, dn: 0};
    drive(v, id++);
    v = '{rst: 0, en: 1, ld: 0, lv: 0, lim: 7, md: DN, c: 7, f: 1, d: 1, dn: 0};
    drive(v, id++);
    v = '{rst: 0, en: 0, ld: 0, lv: 0, lim: 7, md: DN, c: 7, f: 0, d: 1, dn: 0};
    drive(v, id++);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
